// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment types, blank code and hex segment table
package seg_pkg;

  // Active-low segment vector, bit0 = a ... bit6 = g.
  typedef logic [6:0] seg_t;

  // All segments off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low hex glyphs, indexed by nibble value 0..F.
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational 4-bit to active-low 7-segment decoder
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  // Pure table lookup; one instance is shared by every digit of the bank.
  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with framed load port
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int GAP  = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              lzb,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   load_blank,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg
);

  localparam int IDXW = $clog2(NDIG);
  localparam int CNTW = $clog2(DIV);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] CNT_GAP  = CNTW'(DIV - GAP);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

  // Scan position.
  logic [CNTW-1:0]   r_cnt;
  logic [IDXW-1:0]   r_idx;

  // Word currently on the display and the word waiting for a frame boundary.
  logic [4*NDIG-1:0] r_act_data;
  logic [NDIG-1:0]   r_act_blank;
  logic [4*NDIG-1:0] r_pend_data;
  logic [NDIG-1:0]   r_pend_blank;
  logic              r_pend_v;

  // Registered display drive.
  logic [NDIG-1:0]   r_an;
  seg_t              r_seg;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_xfer;
  logic              w_commit;
  logic              w_drive;
  logic [NDIG-1:0]   w_onehot;
  logic [4*NDIG-1:0] w_shift;
  logic [3:0]        w_nib;
  logic              w_forced_blank;
  logic              w_lz_blank;
  logic              w_blank;
  seg_t              w_dec_seg;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = en && w_slot_end && (r_idx == IDX_LAST);
  assign w_drive     = (r_cnt < CNT_GAP);

  // Handshake only when the pending buffer is empty.
  assign w_xfer      = load_valid && !r_pend_v;

  // Pending word moves to active at a frame boundary, or at once while
  // scanning is stopped so the next enable shows fresh data. A commit
  // needs a full buffer and a transfer needs an empty one, so the two
  // can never land on the same edge.
  assign w_commit    = r_pend_v && (w_frame_end || !en);

  // Current digit selection: one-hot position and the nibbles from idx upward.
  assign w_onehot       = NDIG'(1) << r_idx;
  assign w_shift        = r_act_data >> {r_idx, 2'b00};
  assign w_nib          = w_shift[3:0];
  assign w_forced_blank = |(r_act_blank & w_onehot);

  // Leading zero: this digit and every more significant one are zero.
  // Digit 0 always shows so a value of zero still reads "0".
  assign w_lz_blank     = lzb && (r_idx != '0) && (w_shift == '0);
  assign w_blank        = w_forced_blank || w_lz_blank;

  hex7seg_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

  // Slot counter and digit index; held at the start of a frame while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending buffer: captured on a transfer, emptied on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v     <= 1'b0;
      r_pend_data  <= '0;
      r_pend_blank <= '0;
    end else if (w_commit) begin
      r_pend_v     <= 1'b0;
    end else if (w_xfer) begin
      r_pend_v     <= 1'b1;
      r_pend_data  <= load_data;
      r_pend_blank <= load_blank;
    end
  end

  // Active word: only replaced on commit so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data  <= '0;
      r_act_blank <= '1;
    end else if (w_commit) begin
      r_act_data  <= r_pend_data;
      r_act_blank <= r_pend_blank;
    end
  end

  // Anode and segment registers: drive phase, blanking gap, or dark when off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (!en || !w_drive) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~w_onehot;
      r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
    end
  end

  assign load_ready = !r_pend_v;
  assign an         = r_an;
  assign seg        = r_seg;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode 7-segment bank of NDIG digits.
- One hex-to-7-segment decoder instance is shared across all digits. The block walks the digit index, selects one 4-bit nibble at a time, and drives one anode at a time.
- An inter-digit blanking gap suppresses ghosting.
- New display values arrive through a valid/ready load port. They are applied only at frame boundaries, so a frame is never torn.

Parameters:
- NDIG, 4: number of digits; range 2..8.
- DIV, 50000: clock cycles per digit slot; must be at least GAP+2.
- GAP, 500: cycles at the end of each slot with all anodes off; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- lzb  in  1  leading-zero blanking enable; sampled live.
- load_valid  in  1  load request.
- load_ready  out  1  pending buffer empty.
- load_data  in  4*NDIG  nibbles; digit i is in bits [4i+3:4i]; digit 0 is least significant.
- load_blank  in  NDIG  per-digit forced blank, captured with load_data.
- an  out  NDIG  anode select, active-low, one-hot-low when driving.
- seg  out  7  segments, active-low; bit0=a … bit6=g.

Behaviour:
- **Reset (async, rst_n=0).** Counter cnt=0, index idx=0, active data=0, active blank=all 1, pending empty. Outputs: an=all 1, seg=7'h7F, load_ready=1.
- **Single clock.** All state changes on the rising edge of clk.
- **Decoder encoding.** Uses the team's standard active-low hex encoding. Examples: 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- **Slot timing.**
  - cnt counts 0..DIV-1 while en=1.
  - At cnt==DIV-1, cnt returns to 0 and idx increments, wrapping from NDIG-1 to 0.
- **Output latency.** an and seg are registered and reflect (cnt, idx) from the previous cycle.
- **Drive phase (cnt < DIV-GAP).**
  - an[idx]=0 and all other anode bits are 1.
  - seg = decode(active nibble idx), unless that digit is blanked, in which case seg=7'h7F and an[idx] is still 0.
- **Gap phase (cnt ≥ DIV-GAP).** an=all 1, seg=7'h7F.
- **Blanking rule.** Digit idx is blanked if either condition holds:
  - active_blank[idx]=1; or
  - lzb=1, idx≠0, and every active nibble from idx up to NDIG-1 is 0.
  - Digit 0 is never blanked by lzb.
- **Load handshake.**
  - A transfer occurs when load_valid and load_ready are both 1 on a clock edge. load_data and load_blank are captured into the pending buffer.
  - load_ready = !pending_valid, driven from a register. load_ready drops the cycle after acceptance.
- **Frame commit.**
  - Frame end is cnt==DIV-1 with idx==NDIG-1 and en=1.
  - At frame end with pending valid, pending is copied to active and cleared. load_ready returns to 1 the next cycle.
- **Accept at frame end.** If a transfer happens on the same edge as frame end, the new word goes to pending only. It is committed at the next frame end; there is no bypass.
- **Disable (en=0).**
  - cnt and idx are forced to 0, an=all 1, seg=7'h7F.
  - A valid pending word is committed on the first edge with en=0, so the display shows fresh data as soon as it re-enables.
  - The load port keeps working.
- **Re-enable.** Scanning restarts at digit 0, cnt=0; the first drive output appears one cycle after en rises.
- **Reset mid-frame.** All state returns to reset values immediately, including discarding the pending word. The active word resets to all-blank.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'h7F;
  - the hex segment constant table (16 entries);
  - type seg_t, a 7-bit segment vector.
- Sub-module hex7seg_dec: a combinational 4-bit to 7-bit active-low decoder, instantiated once and shared by all digits.
- Scan counter, commit logic and load buffer stay in seg_scan_ctrl.

Test Plan:
- Bench configuration for all scenarios: NDIG=4, DIV=4, GAP=1.
- **Reset values.** Assert rst_n=0 mid-slot → an=4'hF, seg=7'h7F and load_ready=1, asynchronously and without waiting for a clock edge.
- **Scan sequence.**
  - Stimulus: en=1, load 16'h1234 with blank=0; wait for the commit.
  - Response: per slot, three drive cycles then one gap cycle.
  - Digit 0: an=4'hE, seg=7'h19 ('4').
  - Digit 1: an=4'hD, seg=7'h30 ('3').
  - Digit 2: an=4'hB, seg=7'h24 ('2').
  - Digit 3: an=4'h7, seg=7'h79 ('1').
  - Gap cycles: an=4'hF.
- **Handshake back-pressure.**
  - Load 16'hAAAA, then hold load_valid with 16'h5555.
  - load_ready stays 0 until the frame-end edge.
  - 5555 is accepted on the cycle after ready rises and is displayed from the following frame.
- **Accept on frame-end edge.** Transfer 16'h00F0 exactly at cnt=3, idx=3 → the current frame keeps the old data; 00F0 is displayed one full frame later.
- **Leading-zero blanking.**
  - Active 16'h0070 with lzb=1 → digits 3 and 2 show seg=7'h7F with their anode low; digit 1 shows 7'h78; digit 0 shows 7'h40.
  - Setting lzb=0 shows 7'h40 on digits 3 and 2.
- **Disable commit.** With pending 16'hBEEF and en=0 → an=4'hF, commit on the next edge, load_ready=1. On re-enable, the first drive cycle shows digit 0 with seg=7'h0E ('F').
